// File: rtl/clock_set_ctrl.sv
// Time-set controller: 1 Hz count enable in RUN, MODE/INC edit flow, one-cycle parallel load on exit.
// Define CLOCK_SET_TIMEOUT_EN to abort an idle edit after TIMEOUT_S seconds without loading.
module clock_set_ctrl #(
  parameter int CLK_PER_SEC = 100,
  parameter int TIMEOUT_S   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       tick_1hz,
  output logic       load,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_PER_SEC / 2);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [5:0]    edit_min, edit_sec;
  logic          presc_wrap;
  logic          do_load;
  logic          timeout_hit;

  // Values above 59 can arrive from the datapath; any INC folds them back to 0.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  assign presc_wrap = (presc == PRESC_LAST);
  assign mode       = state;

`ifdef CLOCK_SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_S - 1);

  logic [TW-1:0] idle_secs;

  assign timeout_hit = (state != RUN) && !btn_mode && !btn_inc && presc_wrap &&
                       (idle_secs == IDLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_secs <= '0;
    end else if (state == RUN || btn_mode || btn_inc) begin
      idle_secs <= '0;
    end else if (presc_wrap) begin
      idle_secs <= idle_secs + TW'(1);
    end
  end
`else
  // TIMEOUT_S only sizes the abort counter; without it an edit never expires.
  assign timeout_hit = (TIMEOUT_S < 0);
`endif

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    presc_nxt = presc_wrap ? '0 : presc + PW'(1);
    do_load   = 1'b0;
    unique case (state)
      RUN: begin
        if (btn_mode) state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (btn_mode) begin
          state_nxt = SET_SEC;
        end else if (timeout_hit) begin
          state_nxt = RUN;
          presc_nxt = '0;
        end
      end
      SET_SEC: begin
        if (btn_mode) begin
          state_nxt = RUN;
          do_load   = 1'b1;
          presc_nxt = '0;
        end else if (timeout_hit) begin
          state_nxt = RUN;
          presc_nxt = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        presc_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      presc        <= '0;
      edit_min     <= '0;
      edit_sec     <= '0;
      tick_1hz     <= 1'b0;
      load         <= 1'b0;
      load_minutes <= '0;
      load_seconds <= '0;
      blink        <= 1'b0;
    end else begin
      state        <= state_nxt;
      presc        <= presc_nxt;
      tick_1hz     <= (state == RUN) && !btn_mode && presc_wrap;
      load         <= do_load;
      load_minutes <= do_load ? edit_min : '0;
      load_seconds <= do_load ? edit_sec : '0;
      // Computed from next-state values so blink lines up with mode and prescaler.
      blink        <= (state_nxt != RUN) && (presc_nxt >= PRESC_HALF);

      if (state == RUN && btn_mode) begin
        edit_min <= cur_minutes;
        edit_sec <= cur_seconds;
      end else if (!btn_mode && btn_inc) begin
        if (state == SET_MIN) edit_min <= wrap_inc(edit_min);
        if (state == SET_SEC) edit_sec <= wrap_inc(edit_sec);
      end
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed table, corner sequences, and random
// stimulus compared every cycle against an integer-level behavioural model.
module tb_clock_set_ctrl;

  localparam int N = 10;
  localparam int T = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] cur_minutes = '0;
  logic [5:0] cur_seconds = '0;
  logic       tick_1hz, load, blink;
  logic [5:0] load_minutes, load_seconds;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  clock_set_ctrl #(.CLK_PER_SEC(N), .TIMEOUT_S(T)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .tick_1hz(tick_1hz), .load(load), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0/1/2, phase = cycles since last second boundary.
  int m_mode, m_ph, m_emin, m_esec, m_idle;
  bit e_tick, e_load;
  int e_lmin, e_lsec;

  typedef struct {
    bit bm;
    bit bi;
    int exp_mode;
    bit exp_load;
    int exp_lmin;
    int exp_lsec;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_ph = 0; m_emin = 0; m_esec = 0; m_idle = 0;
    e_tick = 0; e_load = 0; e_lmin = 0; e_lsec = 0;
  endfunction

  function automatic void model_step(input bit bm, input bit bi, input int cm, input int cs);
    bit wrap;
    wrap   = (m_ph == N - 1);
    e_tick = (m_mode == 0) && !bm && wrap;
    e_load = 0; e_lmin = 0; e_lsec = 0;
    m_ph   = wrap ? 0 : m_ph + 1;
    if (m_mode == 0 || bm || bi) m_idle = 0;
    else if (wrap) m_idle++;
    if (bm) begin
      case (m_mode)
        0: begin m_mode = 1; m_emin = cm; m_esec = cs; end
        1: m_mode = 2;
        default: begin
          m_mode = 0; e_load = 1; e_lmin = m_emin; e_lsec = m_esec; m_ph = 0;
        end
      endcase
    end else if (bi) begin
      if (m_mode == 1) m_emin = (m_emin >= 59) ? 0 : m_emin + 1;
      if (m_mode == 2) m_esec = (m_esec >= 59) ? 0 : m_esec + 1;
    end
`ifdef CLOCK_SET_TIMEOUT_EN
    if (m_mode != 0 && m_idle >= T) begin
      m_mode = 0; m_ph = 0; m_idle = 0;
    end
`endif
  endfunction

  task automatic compare_model();
    check("m_tick", tick_1hz, e_tick);
    check("m_load", load, e_load);
    check("m_lmin", load_minutes, e_lmin);
    check("m_lsec", load_seconds, e_lsec);
    check("m_mode", mode, m_mode);
    check("m_blink", blink, (m_mode != 0) && (m_ph >= N / 2));
  endtask

  task automatic step(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    model_step(bm, bi, cur_minutes, cur_seconds);
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    compare_model();
  endtask

  initial begin
    tbl[0] = '{1, 0, 1, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 0, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 0};
    tbl[4] = '{1, 0, 2, 0, 0, 0};
    tbl[5] = '{0, 1, 2, 0, 0, 0};
    tbl[6] = '{0, 1, 2, 0, 0, 0};
    tbl[7] = '{1, 0, 0, 1, 15, 36};

    // Reset state, then free-running ticks.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick", tick_1hz, 0);
    check("rst_load", load, 0);
    check("rst_lmin", load_minutes, 0);
    check("rst_lsec", load_seconds, 0);
    check("rst_mode", mode, 0);
    check("rst_blink", blink, 0);
    rst = 1'b0;
    for (int n = 1; n <= 35; n++) begin
      step(0, 0);
      check("t1_tick", tick_1hz, (n % 10) == 0);
    end

    // 12:34 edit flow from the vector table.
    cur_minutes = 6'd12;
    cur_seconds = 6'd34;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].bm, tbl[i].bi);
      check("t2_mode", mode, tbl[i].exp_mode);
      check("t2_load", load, tbl[i].exp_load);
      check("t2_lmin", load_minutes, tbl[i].exp_lmin);
      check("t2_lsec", load_seconds, tbl[i].exp_lsec);
    end
    for (int k = 1; k <= 12; k++) begin
      step(0, 0);
      check("t2_tick_after_load", tick_1hz, k == 10);
      check("t2_single_load", load, 0);
    end

    // Wrap both fields from 59.
    cur_minutes = 6'd59;
    cur_seconds = 6'd59;
    step(1, 0); step(0, 1); step(1, 0); step(0, 1); step(1, 0);
    check("t3_load", load, 1);
    check("t3_lmin", load_minutes, 0);
    check("t3_lsec", load_seconds, 0);
    check("t3_mode", mode, 0);

    // Simultaneous MODE and INC in SET_MIN: mode wins, inc dropped.
    cur_minutes = 6'd20;
    cur_seconds = 6'd5;
    step(1, 0);
    step(1, 1);
    check("t4_mode", mode, 2);
    step(1, 0);
    check("t4_load", load, 1);
    check("t4_lmin", load_minutes, 20);
    check("t4_lsec", load_seconds, 5);

    // Asynchronous reset in SET_SEC.
    step(1, 0); step(1, 0); step(0, 1);
    check("t5_in_set_sec", mode, 2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_mode_async", mode, 0);
    check("t5_load_async", load, 0);
    check("t5_tick_async", tick_1hz, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("t5_load_in_rst", load, 0);
      check("t5_mode_in_rst", mode, 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(0, 0);
      check("t5_tick", tick_1hz, k == 10);
      check("t5_no_load", load, 0);
    end

    // Idle in SET_MIN: aborts only with the timeout feature built in.
    step(1, 0);
    for (int k = 0; k < 31; k++) begin
      step(0, 0);
      check("t6_no_load", load, 0);
    end
`ifdef CLOCK_SET_TIMEOUT_EN
    check("t6_mode", mode, 0);
`else
    check("t6_mode", mode, 1);
    step(1, 0);
    step(1, 0);
    check("t6_exit_load", load, 1);
`endif

    // Random stimulus, including out-of-range captures.
    for (int c = 0; c < 3000; c++) begin
      cur_minutes = 6'($urandom_range(0, 63));
      cur_seconds = 6'($urandom_range(0, 63));
      step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
